// File: rtl/alu_ctrl_stage.sv
// -----------------------------------------------------------------------------
// alu_ctrl_stage
//
// RV32I ALU control decoder with a registered ID/EX stage.
//
// In ID, ALUOp/funct3/funct7 are decoded into a compact control word:
// base integer ops, shifts, slt/sltu, and (optionally) the M extension.
// The control word and its flags are registered into EX under reset, flush,
// internal busy-hold and stall control. Multi-cycle mul/div ops are tracked
// by a small IDLE/BUSY sequencer whose BusyE output lets the hazard unit
// stall the D/E stages until the op completes.
//
// Configuration macro:
//   ALU_MULDIV_EN  defined   -> M-extension ops decoded, sequencer built.
//                  undefined -> M-extension encodings flagged illegal,
//                               BusyE/DoneE tied low, no sequencer.
//
// Parameters:
//   CTRL_W   ALUControlE width (>= 5); codes are zero-extended
//   MUL_LAT  EX cycles for mul/mulh/mulhsu/mulhu (>= 1)
//   DIV_LAT  EX cycles for div/divu/rem/remu (>= 1)
//   CNT_W    busy counter width; 2**CNT_W > max(MUL_LAT, DIV_LAT)
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   synchronous, active-high
//   StallE       in   hold the EX register
//   FlushE       in   load a bubble into EX (aborts a mul/div in flight)
//   ValidD       in   ID holds a real instruction
//   opb5         in   op[5]: 1 = R-type, 0 = I-type
//   funct3       in   instr[14:12]
//   funct7b5     in   instr[30]
//   funct7b0     in   instr[25], M-extension select
//   ALUOp        in   00 add, 01 sub, 10 funct decode, 11 illegal
//   ALUControlE  out  registered control word
//   ValidE       out  EX holds a valid op
//   IllegalE     out  EX op is undecodable
//   MulDivE      out  EX op is an M-extension op
//   BusyE        out  mul/div in progress, EX frozen
//   DoneE        out  one-cycle pulse when the mul/div result is valid
// -----------------------------------------------------------------------------
module alu_ctrl_stage #(
  parameter int CTRL_W  = 5,
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 32,
  parameter int CNT_W   = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              StallE,
  input  logic              FlushE,
  input  logic              ValidD,
  input  logic              opb5,
  input  logic [2:0]        funct3,
  input  logic              funct7b5,
  input  logic              funct7b0,
  input  logic [1:0]        ALUOp,
  output logic [CTRL_W-1:0] ALUControlE,
  output logic              ValidE,
  output logic              IllegalE,
  output logic              MulDivE,
  output logic              BusyE,
  output logic              DoneE
);

  // Parameter sanity check at elaboration time.
  if (CTRL_W < 5 || MUL_LAT < 1 || DIV_LAT < 1 ||
      (2 ** CNT_W) <= MUL_LAT || (2 ** CNT_W) <= DIV_LAT) begin : g_param_check
    $error("alu_ctrl_stage: illegal parameter combination");
  end

  // Control word encodings (5-bit core, zero-extended to CTRL_W).
  localparam logic [4:0] C_ADD  = 5'b00000;
  localparam logic [4:0] C_SUB  = 5'b00001;
  localparam logic [4:0] C_AND  = 5'b00010;
  localparam logic [4:0] C_OR   = 5'b00011;
  localparam logic [4:0] C_XOR  = 5'b00100;
  localparam logic [4:0] C_SLT  = 5'b00101;
  localparam logic [4:0] C_SLTU = 5'b00110;
  localparam logic [4:0] C_SLL  = 5'b00111;
  localparam logic [4:0] C_SRL  = 5'b01000;
  localparam logic [4:0] C_SRA  = 5'b01001;

  // ---------------------------------------------------------------------------
  // ID-stage decode (combinational)
  // ---------------------------------------------------------------------------
  logic [4:0] ctrl_d;
  logic       illegal_d;
  logic       muldiv_d;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case statements leaves it unassigned and infers a latch.
    ctrl_d    = C_ADD;
    illegal_d = 1'b0;
    muldiv_d  = 1'b0;
    case (ALUOp)
      2'b00: ctrl_d = C_ADD;
      2'b01: ctrl_d = C_SUB;
      2'b10: begin
        if (opb5 && funct7b0) begin
`ifdef ALU_MULDIV_EN
          muldiv_d = 1'b1;
          ctrl_d   = {2'b10, funct3};
`else
          // M-extension encoding without hardware support.
          illegal_d = 1'b1;
`endif
        end else begin
          case (funct3)
            3'b000: ctrl_d = (opb5 && funct7b5) ? C_SUB : C_ADD;
            3'b001: ctrl_d = C_SLL;
            3'b010: ctrl_d = C_SLT;
            3'b011: ctrl_d = C_SLTU;
            3'b100: ctrl_d = C_XOR;
            // srai and sra share instr[30], so no opb5 qualification here.
            3'b101: ctrl_d = funct7b5 ? C_SRA : C_SRL;
            3'b110: ctrl_d = C_OR;
            3'b111: ctrl_d = C_AND;
          endcase
        end
      end
      default: illegal_d = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Mul/div sequencer
  // ---------------------------------------------------------------------------
  // EX accepts a new op only when not flushed, not busy-held and not stalled.
  logic load_en;
  assign load_en = !FlushE && !BusyE && !StallE;

`ifdef ALU_MULDIV_EN
  typedef enum logic {S_IDLE, S_BUSY} state_t;

  // The counter holds the number of EX cycles remaining after the current one.
  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             start;

  assign start = load_en && ValidD && muldiv_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (FlushE) begin
      // Abort: the result of the in-flight op is discarded, no DoneE.
      state_d = S_IDLE;
      cnt_d   = '0;
    end else if (start) begin
      // Also taken in the DoneE cycle, so back-to-back M-ops chain cleanly.
      state_d = S_BUSY;
      cnt_d   = funct3[2] ? DIV_CNT : MUL_CNT;
    end else if (state_q == S_BUSY) begin
      if (cnt_q == '0) begin
        state_d = S_IDLE;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A latency of 1 loads a zero count, which yields DoneE in the first EX
  // cycle without ever raising BusyE.
  assign BusyE = (state_q == S_BUSY) && (cnt_q != '0);
  assign DoneE = (state_q == S_BUSY) && (cnt_q == '0);
`else
  assign BusyE = 1'b0;
  assign DoneE = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // ID/EX register
  // ---------------------------------------------------------------------------
  // Priority: reset > FlushE > busy hold > StallE > load. Reset and flush both
  // load a bubble (add, all flags clear); an invalid ID op loads the same.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (reset || FlushE) begin
      ALUControlE <= CTRL_W'(C_ADD);
      ValidE      <= 1'b0;
      IllegalE    <= 1'b0;
      MulDivE     <= 1'b0;
    end else if (load_en) begin
      if (ValidD) begin
        ALUControlE <= CTRL_W'(ctrl_d);
        ValidE      <= 1'b1;
        IllegalE    <= illegal_d;
        MulDivE     <= muldiv_d;
      end else begin
        ALUControlE <= CTRL_W'(C_ADD);
        ValidE      <= 1'b0;
        IllegalE    <= 1'b0;
        MulDivE     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_ctrl_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_ctrl_stage
//
// Scoreboard bench for alu_ctrl_stage. Each stimulus cycle drives the ID
// inputs and pushes the hand-computed EX outputs expected after the next
// rising edge; a separate monitor pops one entry per cycle on the falling
// edge and compares. M-extension sequences are exercised when ALU_MULDIV_EN
// is defined; otherwise the same encodings are expected to be illegal.
// -----------------------------------------------------------------------------
module tb_alu_ctrl_stage;

  localparam int CTRL_W  = 6;
  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 32;
  localparam int CNT_W   = 6;

  logic              clk = 1'b0;
  logic              reset;
  logic              StallE;
  logic              FlushE;
  logic              ValidD;
  logic              opb5;
  logic [2:0]        funct3;
  logic              funct7b5;
  logic              funct7b0;
  logic [1:0]        ALUOp;
  logic [CTRL_W-1:0] ALUControlE;
  logic              ValidE;
  logic              IllegalE;
  logic              MulDivE;
  logic              BusyE;
  logic              DoneE;

  alu_ctrl_stage #(
    .CTRL_W (CTRL_W),
    .MUL_LAT(MUL_LAT),
    .DIV_LAT(DIV_LAT),
    .CNT_W  (CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .StallE     (StallE),
    .FlushE     (FlushE),
    .ValidD     (ValidD),
    .opb5       (opb5),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .funct7b0   (funct7b0),
    .ALUOp      (ALUOp),
    .ALUControlE(ALUControlE),
    .ValidE     (ValidE),
    .IllegalE   (IllegalE),
    .MulDivE    (MulDivE),
    .BusyE      (BusyE),
    .DoneE      (DoneE)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CTRL_W-1:0] ctrl;
    logic              valid;
    logic              ill;
    logic              md;
    logic              busy;
    logic              done;
    string             name;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  // ---------------------------------------------------------------------------
  // Monitor: one expected entry per clock edge, compared mid-cycle.
  // ---------------------------------------------------------------------------
  task automatic check(input exp_t e);
    total++;
    if ({ALUControlE, ValidE, IllegalE, MulDivE, BusyE, DoneE} !==
        {e.ctrl, e.valid, e.ill, e.md, e.busy, e.done}) begin
      bad++;
      $display("FAIL %s: got ctrl=%b v=%b ill=%b md=%b busy=%b done=%b, want ctrl=%b v=%b ill=%b md=%b busy=%b done=%b",
               e.name, ALUControlE, ValidE, IllegalE, MulDivE, BusyE, DoneE,
               e.ctrl, e.valid, e.ill, e.md, e.busy, e.done);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      @(negedge clk);
      if (sb.size() > 0) check(sb.pop_front());
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic drive_id(input logic vd, input logic ob5, input logic [2:0] f3,
                          input logic f7b5, input logic f7b0, input logic [1:0] op);
    ValidD   = vd;
    opb5     = ob5;
    funct3   = f3;
    funct7b5 = f7b5;
    funct7b0 = f7b0;
    ALUOp    = op;
  endtask

  // Push the outputs expected after the coming edge, then advance one cycle.
  task automatic cycle(input logic [CTRL_W-1:0] c, input logic v, input logic il,
                       input logic m, input logic b, input logic d, input string nm);
    exp_t e;
    e.ctrl  = c;
    e.valid = v;
    e.ill   = il;
    e.md    = m;
    e.busy  = b;
    e.done  = d;
    e.name  = nm;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Hand-computed codes for ALUOp=10 with funct7b0=0, indexed by funct3
  // (opb5&funct7b5 turns 000 into sub; funct7b5 turns 101 into sra).
  logic [CTRL_W-1:0] base_code [8];
  initial begin
    base_code[0] = 6'b000000;
    base_code[1] = 6'b000111;
    base_code[2] = 6'b000101;
    base_code[3] = 6'b000110;
    base_code[4] = 6'b000100;
    base_code[5] = 6'b001000;
    base_code[6] = 6'b000011;
    base_code[7] = 6'b000010;
  end

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [CTRL_W-1:0] exp_code;

    reset  = 1'b1;
    StallE = 1'b0;
    FlushE = 1'b0;
    drive_id(1'b1, 1'b1, 3'b000, 1'b1, 1'b0, 2'b01);
    cycle(6'b000000, 0, 0, 0, 0, 0, "reset_c1");
    cycle(6'b000000, 0, 0, 0, 0, 0, "reset_c2");
    reset = 1'b0;

    drive_id(1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 2'b00);
    cycle(6'b000000, 1, 0, 0, 0, 0, "aluop00_add");
    drive_id(1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 2'b01);
    cycle(6'b000001, 1, 0, 0, 0, 0, "aluop01_sub");

    for (int ob = 0; ob < 2; ob++) begin
      for (int f7 = 0; f7 < 2; f7++) begin
        for (int f = 0; f < 8; f++) begin
          exp_code = base_code[f];
          if (f == 0 && ob == 1 && f7 == 1) exp_code = 6'b000001;
          if (f == 5 && f7 == 1) exp_code = 6'b001001;
          drive_id(1'b1, 1'(ob), 3'(f), 1'(f7), 1'b0, 2'b10);
          cycle(exp_code, 1, 0, 0, 0, 0, $sformatf("sweep_ob%0d_f7%0d_f3%0d", ob, f7, f));
        end
      end
    end

    // I-type with instr[25] set is not an M-op.
    drive_id(1'b1, 1'b0, 3'b000, 1'b0, 1'b1, 2'b10);
    cycle(6'b000000, 1, 0, 0, 0, 0, "itype_f7b0_add");

    drive_id(1'b0, 1'b1, 3'b000, 1'b1, 1'b0, 2'b01);
    cycle(6'b000000, 0, 0, 0, 0, 0, "invalid_id_bubble");

    drive_id(1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 2'b11);
    cycle(6'b000000, 1, 1, 0, 0, 0, "aluop11_illegal");

    FlushE = 1'b1;
    drive_id(1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 2'b01);
    cycle(6'b000000, 0, 0, 0, 0, 0, "flush_bubble");
    FlushE = 1'b0;

    drive_id(1'b1, 1'b0, 3'b110, 1'b0, 1'b0, 2'b10);
    cycle(6'b000011, 1, 0, 0, 0, 0, "pre_stall_or");
    StallE = 1'b1;
    drive_id(1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 2'b01);
    cycle(6'b000011, 1, 0, 0, 0, 0, "stall_hold_1");
    cycle(6'b000011, 1, 0, 0, 0, 0, "stall_hold_2");
    StallE = 1'b0;
    cycle(6'b000001, 1, 0, 0, 0, 0, "stall_release_sub");

`ifdef ALU_MULDIV_EN
    // div: 31 busy cycles, DoneE in cycle 32, ID op held off until then.
    drive_id(1'b1, 1'b1, 3'b100, 1'b0, 1'b1, 2'b10);
    cycle(6'b010100, 1, 0, 1, 1, 0, "div_busy_1");
    drive_id(1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 2'b01);
    for (int i = 2; i <= 31; i++)
      cycle(6'b010100, 1, 0, 1, 1, 0, $sformatf("div_busy_%0d", i));
    cycle(6'b010100, 1, 0, 1, 0, 1, "div_done_32");
    cycle(6'b000001, 1, 0, 0, 0, 0, "div_next_op");

    // mulhu to completion with MUL_LAT=4.
    drive_id(1'b1, 1'b1, 3'b011, 1'b0, 1'b1, 2'b10);
    cycle(6'b010011, 1, 0, 1, 1, 0, "mulhu_busy_1");
    drive_id(1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 2'b01);
    cycle(6'b010011, 1, 0, 1, 1, 0, "mulhu_busy_2");
    cycle(6'b010011, 1, 0, 1, 1, 0, "mulhu_busy_3");
    cycle(6'b010011, 1, 0, 1, 0, 1, "mulhu_done_4");
    cycle(6'b000001, 1, 0, 0, 0, 0, "mulhu_next_op");

    // mul aborted by FlushE in its 2nd busy cycle: no DoneE afterwards.
    drive_id(1'b1, 1'b1, 3'b000, 1'b0, 1'b1, 2'b10);
    cycle(6'b010000, 1, 0, 1, 1, 0, "mul_busy_1");
    drive_id(1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 2'b01);
    cycle(6'b010000, 1, 0, 1, 1, 0, "mul_busy_2");
    FlushE = 1'b1;
    cycle(6'b000000, 0, 0, 0, 0, 0, "mul_flushed");
    FlushE = 1'b0;
    drive_id(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 2'b00);
    for (int i = 0; i < 4; i++)
      cycle(6'b000000, 0, 0, 0, 0, 0, $sformatf("mul_no_done_%0d", i));

    // Reset mid-operation aborts like a flush.
    drive_id(1'b1, 1'b1, 3'b101, 1'b0, 1'b1, 2'b10);
    cycle(6'b010101, 1, 0, 1, 1, 0, "divu_busy_1");
    reset = 1'b1;
    drive_id(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 2'b00);
    cycle(6'b000000, 0, 0, 0, 0, 0, "divu_reset");
    reset = 1'b0;
    cycle(6'b000000, 0, 0, 0, 0, 0, "divu_no_done_1");
    cycle(6'b000000, 0, 0, 0, 0, 0, "divu_no_done_2");
`else
    // Without M support the same encodings are illegal and never busy.
    drive_id(1'b1, 1'b1, 3'b000, 1'b0, 1'b1, 2'b10);
    cycle(6'b000000, 1, 1, 0, 0, 0, "mul_illegal");
    drive_id(1'b1, 1'b1, 3'b100, 1'b0, 1'b1, 2'b10);
    cycle(6'b000000, 1, 1, 0, 0, 0, "div_illegal");
    drive_id(1'b1, 1'b1, 3'b111, 1'b0, 1'b0, 2'b10);
    cycle(6'b000010, 1, 0, 0, 0, 0, "after_illegal_and");
    drive_id(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 2'b00);
    cycle(6'b000000, 0, 0, 0, 0, 0, "after_illegal_idle");
`endif

    // Let the monitor drain the scoreboard, with a bounded wait.
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d entries left, want 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
